// File: rtl/layer_seq_ctrl.sv
// Convolutional layer sequencer. It loads the weights and streams the feature map for each input
// channel, then accumulates the results into the output BRAM by read-modify-write.
module layer_seq_ctrl #(
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned IN_FM_CH    = 4,
  parameter int unsigned OUT_FM_CH   = 2,
  parameter int unsigned NUM_PE      = 2,
  parameter int unsigned DW          = 16,
  parameter int unsigned IN_WORDS    = 84,
  parameter int unsigned OUT_WORDS   = 14,
  parameter int unsigned RELU_EN     = 1,
  parameter int unsigned BIAS_EN     = 1,
  localparam int unsigned KK    = KERNEL_SIZE * KERNEL_SIZE,
  localparam int unsigned LANES = NUM_PE * OUT_FM_CH,
  localparam int unsigned CHW   = $clog2(IN_FM_CH) + 1,
  localparam int unsigned WAW   = $clog2(KK) + 1,
  localparam int unsigned FAW   = $clog2(IN_WORDS) + 1,
  localparam int unsigned OAW   = $clog2(OUT_WORDS) + 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [DW*OUT_FM_CH-1:0] i_bias,
  input  logic                    i_conv_valid,
  input  logic [DW*LANES-1:0]     i_conv_result,
  input  logic [DW*LANES-1:0]     i_out_rdata,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [CHW-1:0]          o_ch_sel,
  output logic [WAW-1:0]          o_weight_addr,
  output logic                    o_weight_en,
  output logic [FAW-1:0]          o_fm_addr,
  output logic                    o_go,
  output logic                    o_conv_rst,
  output logic [OAW-1:0]          o_out_raddr,
  output logic                    o_out_we,
  output logic [OAW-1:0]          o_out_waddr,
  output logic [DW*LANES-1:0]     o_out_wdata,
  output logic                    o_overflow
);

  localparam logic [WAW-1:0] KkW    = WAW'(KK);
  localparam logic [FAW-1:0] FmLast = FAW'(IN_WORDS - 1);
  localparam logic [OAW-1:0] OutW   = OAW'(OUT_WORDS);
  localparam logic [CHW-1:0] ChLast = CHW'(IN_FM_CH - 1);
  localparam logic signed [DW+1:0] MaxV = {3'b000, {(DW-1){1'b1}}};
  localparam logic signed [DW+1:0] MinV = {3'b111, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StWload, StStream, StDrain, StDone} state_e;
  state_e state_q, state_d;

  logic [CHW-1:0]      ch_q;
  logic [WAW-1:0]      wcnt_q;
  logic [FAW-1:0]      fcnt_q;
  logic [OAW-1:0]      beat_q;
  logic [OAW-1:0]      wr_cnt_q;
  logic                ovf_q;
  logic                s1_valid_q;
  logic [OAW-1:0]      s1_addr_q;
  logic [DW*LANES-1:0] s1_conv_q;
  logic                s2_valid_q;
  logic [OAW-1:0]      s2_addr_q;
  logic [DW*LANES-1:0] s2_data_q;
  logic [DW*LANES-1:0] sum_d;

  logic last_ch, drain_done, active, accept, drop, start_ok, next_ch, enter_wload;

  assign last_ch     = (ch_q == ChLast);
  assign drain_done  = (wr_cnt_q == OutW);
  assign active      = (state_q == StStream) || (state_q == StDrain);
  assign accept      = active && i_conv_valid && (beat_q < OutW);
  assign drop        = active && i_conv_valid && !(beat_q < OutW);
  assign start_ok    = (state_q == StIdle) && i_start;
  assign next_ch     = (state_q == StDrain) && drain_done && !last_ch;
  assign enter_wload = start_ok || next_ch;

  // One lane: accumulate, then bias/saturate/ReLU on the final channel only.
  function automatic logic [DW-1:0] acc_lane(input logic [DW-1:0] conv, input logic [DW-1:0] rdata,
                                             input logic [DW-1:0] bias, input logic first,
                                             input logic last);
    logic signed [DW+1:0] wide;
    logic [DW-1:0]        res;
    wide = {{2{conv[DW-1]}}, conv};
    if (!first) wide = wide + {{2{rdata[DW-1]}}, rdata};
    if (last && BIAS_EN != 0) wide = wide + {{2{bias[DW-1]}}, bias};
    if (wide > MaxV) begin
      res = MaxV[DW-1:0];
    end else if (wide < MinV) begin
      res = MinV[DW-1:0];
    end else begin
      res = wide[DW-1:0];
    end
    if (last && RELU_EN != 0 && res[DW-1]) res = '0;
    return res;
  endfunction

  always_comb begin
    sum_d = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      sum_d[l*DW +: DW] = acc_lane(s1_conv_q[l*DW +: DW], i_out_rdata[l*DW +: DW],
                                   i_bias[(l/int'(NUM_PE))*DW +: DW], ch_q == '0, last_ch);
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (i_start) state_d = StWload;
      StWload:  if (wcnt_q == KkW) state_d = StStream;
      StStream: if (fcnt_q == FmLast) state_d = StDrain;
      StDrain:  if (drain_done) state_d = last_ch ? StDone : StWload;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    o_busy        = (state_q == StWload) || active;
    o_done        = (state_q == StDone);
    o_conv_rst    = (state_q == StIdle) || next_ch;
    o_ch_sel      = ch_q;
    o_weight_addr = ((state_q == StWload) && (wcnt_q < KkW)) ? wcnt_q : '0;
    // Address is issued one cycle ahead of its data
    o_weight_en   = (state_q == StWload) && (wcnt_q != '0);
    o_fm_addr     = (state_q == StStream) ? fcnt_q : '0;
    o_go          = (state_q == StStream);
    o_out_raddr   = accept ? beat_q : '0;
    o_out_we      = s2_valid_q;
    o_out_waddr   = s2_addr_q;
    o_out_wdata   = s2_data_q;
    o_overflow    = ovf_q;
  end

  // Counters and accumulation pipeline
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ch_q       <= '0;
      wcnt_q     <= '0;
      fcnt_q     <= '0;
      beat_q     <= '0;
      wr_cnt_q   <= '0;
      ovf_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_conv_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_addr_q  <= '0;
      s2_data_q  <= '0;
    end else begin
      if (start_ok) begin
        ch_q  <= '0;
        ovf_q <= 1'b0;
      end else begin
        if (next_ch) ch_q <= ch_q + 1'b1;
        if (drop) ovf_q <= 1'b1;
      end

      if (enter_wload) begin
        wcnt_q <= '0;
      end else if ((state_q == StWload) && (wcnt_q != KkW)) begin
        wcnt_q <= wcnt_q + 1'b1;
      end

      if ((state_q == StStream) && (fcnt_q != FmLast)) begin
        fcnt_q <= fcnt_q + 1'b1;
      end else begin
        fcnt_q <= '0;
      end

      if (enter_wload) begin
        beat_q <= '0;
      end else if (accept) begin
        beat_q <= beat_q + 1'b1;
      end

      if (enter_wload) begin
        wr_cnt_q <= '0;
      end else if (s2_valid_q) begin
        wr_cnt_q <= wr_cnt_q + 1'b1;
      end

      s1_valid_q <= accept;
      if (accept) begin
        s1_addr_q <= beat_q;
        s1_conv_q <= i_conv_result;
      end
      s2_valid_q <= s1_valid_q;
      s2_addr_q  <= s1_addr_q;
      s2_data_q  <= sum_d;
    end
  end

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Directed bench for layer_seq_ctrl: two instances (ReLU on/off) share stimulus, and each has its
// own output BRAM model.
module tb_layer_seq_ctrl;

  logic        i_clk;
  logic        i_rst;
  logic        i_start;
  logic [31:0] i_bias;
  logic        i_conv_valid;
  logic [63:0] i_conv_result;

  logic [63:0] rdata_a, rdata_b;
  logic        busy_a, done_a, wen_a, go_a, crst_a, we_a, ovf_a;
  logic        busy_b, done_b, wen_b, go_b, crst_b, we_b, ovf_b;
  logic [1:0]  chs_a, chs_b;
  logic [4:0]  wa_a, wa_b;
  logic [3:0]  fa_a, fa_b;
  logic [2:0]  ra_a, ra_b, waddr_a, waddr_b;
  logic [63:0] wdata_a, wdata_b;

  logic [63:0] mem_a [0:7];
  logic [63:0] mem_b [0:7];

  logic [63:0] wlog_a [0:3][0:7];
  logic [63:0] wlog_b [0:3][0:7];
  int wcnt_a [0:3];
  int wcnt_b [0:3];
  int wen_cnt_a, wen_cnt_b, wsum_a, wsum_b, done_cnt_a, done_cnt_b;
  logic [4:0] prev_wa_a, prev_wa_b;
  int checks, failures;

  layer_seq_ctrl #(
    .KERNEL_SIZE(3), .IN_FM_CH(2), .OUT_FM_CH(2), .NUM_PE(2), .DW(16),
    .IN_WORDS(8), .OUT_WORDS(4), .RELU_EN(1), .BIAS_EN(1)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_bias(i_bias),
    .i_conv_valid(i_conv_valid), .i_conv_result(i_conv_result), .i_out_rdata(rdata_a),
    .o_busy(busy_a), .o_done(done_a), .o_ch_sel(chs_a), .o_weight_addr(wa_a),
    .o_weight_en(wen_a), .o_fm_addr(fa_a), .o_go(go_a), .o_conv_rst(crst_a),
    .o_out_raddr(ra_a), .o_out_we(we_a), .o_out_waddr(waddr_a), .o_out_wdata(wdata_a),
    .o_overflow(ovf_a)
  );

  layer_seq_ctrl #(
    .KERNEL_SIZE(3), .IN_FM_CH(2), .OUT_FM_CH(2), .NUM_PE(2), .DW(16),
    .IN_WORDS(8), .OUT_WORDS(4), .RELU_EN(0), .BIAS_EN(1)
  ) dut_nr (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_bias(i_bias),
    .i_conv_valid(i_conv_valid), .i_conv_result(i_conv_result), .i_out_rdata(rdata_b),
    .o_busy(busy_b), .o_done(done_b), .o_ch_sel(chs_b), .o_weight_addr(wa_b),
    .o_weight_en(wen_b), .o_fm_addr(fa_b), .o_go(go_b), .o_conv_rst(crst_b),
    .o_out_raddr(ra_b), .o_out_we(we_b), .o_out_waddr(waddr_b), .o_out_wdata(wdata_b),
    .o_overflow(ovf_b)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Output BRAMs with one-cycle read latency
  always @(posedge i_clk) begin
    if (we_a) mem_a[waddr_a] <= wdata_a;
    if (we_b) mem_b[waddr_b] <= wdata_b;
    rdata_a <= mem_a[ra_a];
    rdata_b <= mem_b[ra_b];
  end

  function automatic logic [63:0] lanes(input logic [15:0] v);
    return {v, v, v, v};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
    if (we_a) begin wlog_a[chs_a][waddr_a] = wdata_a; wcnt_a[chs_a]++; end
    if (we_b) begin wlog_b[chs_b][waddr_b] = wdata_b; wcnt_b[chs_b]++; end
    if (wen_a) begin wen_cnt_a++; wsum_a += int'(prev_wa_a); end
    if (wen_b) begin wen_cnt_b++; wsum_b += int'(prev_wa_b); end
    prev_wa_a = wa_a;
    prev_wa_b = wa_b;
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
  endtask

  task automatic clear_logs();
    for (int c = 0; c < 4; c++) begin
      wcnt_a[c] = 0;
      wcnt_b[c] = 0;
      for (int a = 0; a < 8; a++) begin
        wlog_a[c][a] = '0;
        wlog_b[c][a] = '0;
      end
    end
    wen_cnt_a = 0; wen_cnt_b = 0; wsum_a = 0; wsum_b = 0; done_cnt_a = 0; done_cnt_b = 0;
  endtask

  task automatic pulse_start(input logic extra);
    i_start = 1'b1;
    tick();
    i_start = extra;
    tick();
    i_start = 1'b0;
  endtask

  // Wait for the first stream cycle of channel ch, then drive nb back-to-back beats
  task automatic do_chan(input int ch, input logic [15:0] v, input int nb);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (go_a && go_b && fa_a == 4'd0 && fa_b == 4'd0) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk($sformatf("go_seen_ch%0d", ch), found, 1'b1);
    chk($sformatf("ch_sel_ch%0d", ch), {chs_b, chs_a}, {2'(ch), 2'(ch)});
    for (int i = 0; i < nb; i++) begin
      i_conv_valid  = 1'b1;
      i_conv_result = lanes(v);
      tick();
    end
    i_conv_valid = 1'b0;
  endtask

  task automatic wait_done();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done_cnt_a > 0) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("done_seen", found, 1'b1);
    tick();
    tick();
  endtask

  task automatic run_layer(input logic [15:0] v0, input logic [15:0] v1, input logic [15:0] bias,
                           input int nb0, input logic extra);
    clear_logs();
    i_bias = {bias, bias};
    pulse_start(extra);
    do_chan(0, v0, nb0);
    do_chan(1, v1, 4);
    wait_done();
  endtask

  task automatic check_layer(input string tag, input logic [15:0] e0, input logic [15:0] e1a,
                             input logic [15:0] e1b, input int nw0);
    chk({tag, "_nwr0"}, 64'(wcnt_a[0]), 64'(nw0));
    chk({tag, "_nwr1"}, 64'(wcnt_a[1]), 64'd4);
    chk({tag, "_nwr1_nr"}, 64'(wcnt_b[1]), 64'd4);
    for (int a = 0; a < 4; a++) begin
      chk($sformatf("%s_ch0_a%0d", tag, a), wlog_a[0][a], lanes(e0));
      chk($sformatf("%s_ch1_a%0d", tag, a), wlog_a[1][a], lanes(e1a));
      chk($sformatf("%s_ch1_nr_a%0d", tag, a), wlog_b[1][a], lanes(e1b));
    end
    chk({tag, "_ch0_nr"}, wlog_b[0][3], lanes(e0));
    chk({tag, "_wen_cnt"}, 64'(wen_cnt_a), 64'd18);
    chk({tag, "_wen_cnt_nr"}, 64'(wen_cnt_b), 64'd18);
    chk({tag, "_waddr_sum"}, 64'(wsum_a), 64'd72);
    chk({tag, "_waddr_sum_nr"}, 64'(wsum_b), 64'd72);
    chk({tag, "_done_once"}, 64'(done_cnt_a), 64'd1);
    chk({tag, "_done_once_nr"}, 64'(done_cnt_b), 64'd1);
    chk({tag, "_idle"}, {busy_b, busy_a, crst_b, crst_a}, 4'b0011);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    i_rst = 1'b1;
    i_start = 1'b0;
    i_bias = '0;
    i_conv_valid = 1'b0;
    i_conv_result = '0;
    prev_wa_a = '0;
    prev_wa_b = '0;
    clear_logs();
    tick();
    tick();
    chk("rst_ctrl", {busy_a, done_a, crst_a, we_a, ovf_a, wen_a, go_a}, 7'b0010000);
    chk("rst_ctrl_nr", {busy_b, done_b, crst_b, we_b, ovf_b, wen_b, go_b}, 7'b0010000);
    chk("rst_addr", {chs_a, wa_a, fa_a, ra_a, waddr_a}, '0);
    i_rst = 1'b0;
    tick();

    // Basic layer with bias, plus a start pulse during WLOAD that must be ignored
    run_layer(16'd10, 16'd10, 16'd5, 4, 1'b1);
    check_layer("basic", 16'd10, 16'd25, 16'd25, 4);
    chk("basic_ovf", {ovf_b, ovf_a}, 2'b00);

    // Negative final: ReLU clamps, non-ReLU keeps -17
    run_layer(16'hFFEC, 16'd3, 16'd0, 4, 1'b0);
    check_layer("relu", 16'hFFEC, 16'd0, 16'hFFEF, 4);

    // Positive and negative saturation
    run_layer(16'd30000, 16'd30000, 16'd0, 4, 1'b0);
    check_layer("satpos", 16'd30000, 16'h7FFF, 16'h7FFF, 4);
    run_layer(16'h8AD0, 16'h8AD0, 16'd0, 4, 1'b0);
    check_layer("satneg", 16'h8AD0, 16'd0, 16'h8000, 4);

    // Five beats in channel 0: fifth dropped, overflow sticky
    run_layer(16'd5, 16'd5, 16'd0, 5, 1'b0);
    check_layer("ovf", 16'd5, 16'd10, 16'd10, 4);
    chk("ovf_set", {ovf_b, ovf_a}, 2'b11);

    // Reset in channel-1 stream aborts with no further writes; next start clears overflow
    clear_logs();
    i_bias = '0;
    pulse_start(1'b0);
    chk("ovf_cleared", {ovf_b, ovf_a}, 2'b00);
    do_chan(0, 16'd7, 4);
    do_chan(1, 16'd9, 0);
    i_conv_valid = 1'b1;
    i_conv_result = lanes(16'd9);
    i_rst = 1'b1;
    tick();
    chk("abort_state", {busy_a, we_a, crst_a, busy_b, we_b, crst_b}, 6'b001001);
    i_rst = 1'b0;
    i_conv_valid = 1'b0;
    repeat (5) tick();
    chk("abort_nowr", 64'(wcnt_a[1] + wcnt_b[1]), 64'd0);
    chk("abort_ch0_wr", 64'(wcnt_a[0]), 64'd4);
    chk("abort_idle", {busy_a, crst_a, done_cnt_a[0]}, 3'b010);

    // Restart after abort completes normally
    run_layer(16'd1, 16'd2, 16'd5, 4, 1'b0);
    check_layer("restart", 16'd1, 16'd8, 16'd8, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/layer_seq_ctrl.md
Name: layer_seq_ctrl

Overview:
- Next-generation convolutional layer sequencer. It walks all input channels of one layer: loads kernel weights, streams the feature map into an external array of conv blocks, and accumulates per-channel partial sums in the output BRAM via read-modify-write.
- Beyond the previous layer controller it adds: explicit start/busy/done handshake, zero-initialised first-channel accumulation, bias add and optional ReLU on the final channel, saturating arithmetic, and beat-overflow detection.
- Sits between the weight/FM/output BRAMs and OUT_FM_CH conv-block instances, each with NUM_PE PEs.

Parameters:
- KERNEL_SIZE, 3: kernel side; KERNEL_SIZE**2 weight words per channel.
- IN_FM_CH, 4: input channels accumulated per layer.
- OUT_FM_CH, 2: output channels processed in parallel.
- NUM_PE, 2: PEs per conv block; each yields one result per beat.
- DW, 16: signed result/accumulator width.
- IN_WORDS, 84: FM BRAM words streamed per input channel.
- OUT_WORDS, 14: result beats (output BRAM addresses) per input channel.
- RELU_EN, 1: 1 = clamp negative final results to 0.
- BIAS_EN, 1: 1 = add i_bias on the final channel.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset
- i_start  in  1  one-cycle layer start pulse; ignored unless idle
- i_bias  in  DW*OUT_FM_CH  signed bias per output channel
- i_conv_valid  in  1  conv array result beat valid
- i_conv_result  in  DW*NUM_PE*OUT_FM_CH  signed results; lane index = och*NUM_PE+pe
- i_out_rdata  in  DW*NUM_PE*OUT_FM_CH  output BRAM read data
- o_busy  out  1  high from accepted start until o_done
- o_done  out  1  one-cycle pulse at layer end
- o_ch_sel  out  clog2(IN_FM_CH)+1  current input channel, drives FM selector
- o_weight_addr  out  clog2(KERNEL_SIZE**2)+1  weight BRAM read address
- o_weight_en  out  1  weight word valid to conv blocks
- o_fm_addr  out  clog2(IN_WORDS)+1  FM BRAM read address
- o_go  out  1  FM stream enable to conv blocks
- o_conv_rst  out  1  conv block reset
- o_out_raddr  out  clog2(OUT_WORDS)+1  output BRAM read address
- o_out_we  out  1  output BRAM write enable
- o_out_waddr  out  clog2(OUT_WORDS)+1  output BRAM write address
- o_out_wdata  out  DW*NUM_PE*OUT_FM_CH  accumulated results
- o_overflow  out  1  sticky: more than OUT_WORDS beats in one channel

Behaviour:
- Reset: i_rst is synchronous, active-high, on clock i_clk. Forces IDLE; all outputs 0 except o_conv_rst=1. Reset mid-operation aborts immediately with no further writes.
- States: IDLE, WLOAD, STREAM, DRAIN, DONE.
- IDLE:
  - o_conv_rst=1, o_busy=0.
  - i_start → WLOAD, o_ch_sel=0, o_overflow cleared.
  - i_start during any other state is ignored.
- WLOAD:
  - o_conv_rst=0.
  - o_weight_addr steps 0..K²-1, one per cycle.
  - o_weight_en is high exactly K² cycles, lagging the address by 1 cycle (BRAM latency).
  - After the cycle with o_weight_en for address K²-1 → STREAM.
- STREAM:
  - o_fm_addr steps 0..IN_WORDS-1.
  - o_go=1 on each of those IN_WORDS cycles.
  - After the last address → DRAIN with o_go=0, o_fm_addr=0.
- Accumulation (active in STREAM and DRAIN):
  - Beat counter b resets to 0 at each WLOAD entry.
  - Cycle t, i_conv_valid=1 with b<OUT_WORDS:
    - o_out_raddr=b (combinational);
    - conv data and b are registered; b increments.
  - Cycle t+1: read data is valid. Per lane, sum = conv + (ch==0 ? 0 : rdata).
  - Final channel only (ch==IN_FM_CH-1):
    - if BIAS_EN, add i_bias lane of that och;
    - saturate to the signed DW range;
    - if RELU_EN, negative → 0.
  - All channels: sums saturate to [-2^(DW-1), 2^(DW-1)-1].
  - Cycle t+2: o_out_we=1, o_out_waddr=b, o_out_wdata=sum.
  - Valid-to-write latency is 2 cycles; back-to-back beats give back-to-back writes.
  - Beats with b≥OUT_WORDS are dropped (no write) and set o_overflow.
  - i_conv_valid in IDLE/WLOAD/DONE is ignored.
- DRAIN:
  - Waits until OUT_WORDS writes of this channel have completed.
  - Then: if ch<IN_FM_CH-1, ch++ and pulse o_conv_rst for 1 cycle → WLOAD; else → DONE.
- DONE: o_done=1 for one cycle, o_busy falls in the same cycle → IDLE.
- Intermediate sums are stored in the output BRAM at DW width; the final result is the stored value of the last channel.

Test Plan:
- Params K=3, IN_FM_CH=2, OUT_FM_CH=2, NUM_PE=2, DW=16, IN_WORDS=8, OUT_WORDS=4, RELU_EN=1, BIAS_EN=1.
- Start pulse, conv model returns 4 beats of all-lanes=10 per channel, bias=5 → writes per channel: ch0 addr0..3 data 10, ch1 data 25; o_weight_en 9 cycles per channel; o_done exactly once; o_busy low afterwards.
- ch0 results -20, ch1 results +3, bias 0 → final data 0 (ReLU); same with RELU_EN=0 → -17.
- ch0 and ch1 results 30000 each → final data 32767 (saturated), no wrap.
- 5 beats in one channel → 4 writes only, o_overflow=1 until next i_start.
- Assert i_rst during ch1 STREAM → next cycle IDLE, o_out_we=0, o_conv_rst=1. Restart completes normally.
- i_start pulsed during WLOAD → ignored; exactly one o_done.
